// File: rtl/risc16_imem_loader.sv
// RiSC-16 boot loader: streams a framed image into instruction memory
// and keeps the core in reset until the image checksum has been verified.
module risc16_imem_loader #(
   parameter int          ADDR_W = 8,
   parameter logic [7:0]  MAGIC  = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              error
);

   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN_HI  = 3'd1;
   localparam logic [2:0] S_LEN_LO  = 3'd2;
   localparam logic [2:0] S_DATA_HI = 3'd3;
   localparam logic [2:0] S_DATA_LO = 3'd4;
   localparam logic [2:0] S_CSUM    = 3'd5;
   localparam logic [2:0] S_RUN     = 3'd6;
   localparam logic [2:0] S_ERR     = 3'd7;

   logic [2:0]      state;
   logic [7:0]      len_hi;
   logic [7:0]      hi_byte;
   logic [7:0]      xsum;
   logic [15:0]     n_words;
   logic [ADDR_W:0] idx;
   logic [ADDR_W:0] idx_nx;
   logic [15:0]     n_cur;
   logic            len_bad;
   logic            accept;

   // Word index is one bit wider than the address so N == DEPTH fits.
   assign idx_nx  = idx + {{ADDR_W{1'b0}}, 1'b1};
   assign n_cur   = {len_hi, in_data};
   assign len_bad = (n_cur == 16'd0) || (32'(n_cur) > DEPTH);

   assign in_ready = !rst && !start
                   && (state != S_RUN) && (state != S_ERR);
   assign accept   = in_valid && in_ready;

   // Frame parser, memory write port and core-reset control.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         len_hi     <= 8'd0;
         hi_byte    <= 8'd0;
         xsum       <= 8'd0;
         n_words    <= 16'd0;
         idx        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 16'd0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else if (start) begin
         state     <= S_IDLE;
         imem_we   <= 1'b0;
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (in_data == MAGIC)
                     state <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  if (len_bad) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     n_words <= n_cur;
                     idx     <= '0;
                     xsum    <= 8'd0;
                     state   <= S_DATA_HI;
                  end
               end
               S_DATA_HI: begin
                  hi_byte <= in_data;
                  xsum    <= xsum ^ in_data;
                  state   <= S_DATA_LO;
               end
               S_DATA_LO: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= idx[ADDR_W-1:0];
                  imem_wdata <= {hi_byte, in_data};
                  xsum       <= xsum ^ in_data;
                  idx        <= idx_nx;
                  if (16'(idx_nx) == n_words)
                     state <= S_CSUM;
                  else
                     state <= S_DATA_HI;
               end
               S_CSUM: begin
                  if (in_data == xsum) begin
                     state     <= S_RUN;
                     done      <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/risc16_imem_loader.md
# risc16_imem_loader

Boot loader that writes a RiSC-16 program image into instruction memory from a byte stream, holding the processor in reset until the image is complete and verified. It drives the write port of the instruction memory, which the core only reads. It also drives the core's active-low reset. It sits between an external byte source (UART receiver, debug bridge, or testbench) and the `risc16_processor` top level.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- `MAGIC`, default 8'hA5: start-of-image byte.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle pulse: abort any activity and re-enter load mode.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write enable (one-cycle pulse per word).
- `imem_addr`  out  ADDR_W  word address for write.
- `imem_wdata`  out  16  instruction word.
- `cpu_rst_n`  out  1  processor reset, active-low; high only in RUN.
- `done`  out  1  image loaded and checksum matched.
- `error`  out  1  image rejected.

## Operation
- Byte accepted iff `in_valid && in_ready` at a rising edge; no other byte is consumed.
- Image format: MAGIC, LEN_HI, LEN_LO (16-bit word count N, big-endian), 2N payload bytes (each word high byte first), CSUM (XOR of all 2N payload bytes; header excluded).
- States:
  - IDLE: wait for MAGIC. Non-MAGIC bytes are accepted and discarded. MAGIC goes to LEN_HI.
  - LEN_HI goes to LEN_LO.
  - LEN_LO: if N==0 or N>DEPTH, go to ERR; else clear word index and running XOR, go to DATA_HI.
  - DATA_HI: latch high byte, go to DATA_LO.
  - DATA_LO: issue write of {hi,lo} at the current index. Increment the index. If index+1==N go to CSUM, else go to DATA_HI.
  - CSUM: byte==XOR goes to RUN, else goes to ERR.
  - RUN: `done`=1, `cpu_rst_n`=1.
  - ERR: `error`=1, `cpu_rst_n`=0.
- `in_ready` = 1 in IDLE through CSUM; 0 in RUN and ERR; 0 in any cycle where `rst` or `start` is high.
- Running XOR is updated with every accepted payload byte.
- Word index is ADDR_W+1 bits wide internally so that N==DEPTH is legal. `imem_addr` is its low ADDR_W bits; the last write when N==DEPTH is to address DEPTH-1.
- Writes are not rolled back on checksum failure. Memory contents are then undefined and the core stays in reset.
- `start` (any state) forces IDLE next cycle and clears `done`/`error`. `cpu_rst_n` drops to 0 next cycle. A byte presented in the same cycle is not accepted.
- `start` has priority over byte acceptance. `rst` has priority over `start`.
- Leaving RUN or ERR is possible only via `start` or `rst`. Bytes arriving there are stalled, not dropped.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst_n`=0, `done`=0, `error`=0. `in_ready`=0 during the `rst` cycle, 1 in the following cycle.
- All outputs except `in_ready` are registered. `in_ready` is combinational from state, `start`, and `rst`.
- Write latency: `imem_we`=1 for exactly one cycle, the cycle after the DATA_LO byte is accepted, with matching `imem_addr`/`imem_wdata` held in that cycle. `imem_we`=0 in all other cycles.
- Max throughput: one byte per cycle; a back-to-back N-word image completes in 2N+4 accepting cycles.
- `done`, `cpu_rst_n`, and `error` update the cycle after the CSUM byte is accepted (or the LEN_LO byte, for a length error).
- Gaps in `in_valid` stall the state machine without side effects.

## Test plan
- Normal load: stream A5 00 02 12 34 AB CD, CSUM=12^34^AB^CD=40. Expect writes (0,1234) and (1,ABCD) one cycle after each low byte. The cycle after CSUM: `done`=1, `cpu_rst_n`=1, `in_ready`=0.
- Garbage prefix plus backpressure: 00 FF 3C, then the normal image with random `in_valid` gaps. Expect identical writes and result; prefix bytes are consumed with no writes.
- Length errors: A5 00 00 gives `error`=1 after LEN_LO with no writes. With ADDR_W=8, A5 01 01 gives `error`=1. A5 01 00 (N=256) is accepted, and its last write goes to address 255.
- Checksum error: normal image with CSUM=41. Expect both writes, then `error`=1, `done`=0, `cpu_rst_n`=0, `in_ready`=0.
- `start` abort mid-load: after A5 00 02 12, pulse `start` together with `in_valid`/34. Expect 34 not accepted, state IDLE, no write. A subsequent full image loads correctly.
- `rst` in RUN: after a successful load, assert `rst` for one cycle. Expect all outputs return to their reset values next cycle, and `in_ready`=1 the cycle after that.
